// File: rtl/data_ram_dma_if.sv
// Data-RAM bus: req/gnt handshake, read data on rvalid one cycle after the
// granted read, err flagged in the granted cycle.
interface bus_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rdata, rvalid, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rdata, rvalid, err
  );
endinterface

// File: rtl/data_ram_dma.sv
// Word-granular DMA over the data-RAM bus: copies a block between two
// data-RAM addresses, or fills a block with a constant pattern.
module data_ram_dma #(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic [31:0]          fill_data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [LEN_WIDTH-1:0] words_done_o,
  bus_if.master                bus
);

  typedef enum logic [2:0] {StIdle, StRd, StRwait, StWr, StDone} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            src_q, src_d;
  logic [31:0]            dst_q, dst_d;
  logic [31:0]            fill_q, fill_d;
  logic [31:0]            buf_q, buf_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [LEN_WIDTH-1:0]   words_q, words_d;
  logic                   mode_q, mode_d;
  logic                   err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      fill_q  <= '0;
      buf_q   <= '0;
      rem_q   <= '0;
      words_q <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  // Bus outputs depend only on state and registers, so they stay stable
  // while a request waits for its grant.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    fill_d    = fill_q;
    buf_d     = buf_q;
    rem_d     = rem_q;
    words_d   = words_q;
    mode_d    = mode_q;
    err_d     = err_q;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.be    = 4'h0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          src_d   = src_addr_i;
          dst_d   = dst_addr_i;
          rem_d   = len_i;
          mode_d  = mode_i;
          fill_d  = fill_data_i;
          err_d   = 1'b0;
          words_d = '0;
          if (len_i == '0) begin
            state_d = StDone;
          end else if (mode_i) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end

      StRd: begin
        bus.req  = 1'b1;
        bus.be   = 4'hF;
        bus.addr = {src_q[31:2], 2'b00};
        if (bus.gnt) begin
          if (bus.err) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            src_d   = src_q + 32'd4;
            state_d = StRwait;
          end
        end
      end

      StRwait: begin
        if (bus.rvalid) begin
          buf_d   = bus.rdata;
          state_d = StWr;
        end
      end

      StWr: begin
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.be    = 4'hF;
        bus.addr  = {dst_q[31:2], 2'b00};
        bus.wdata = mode_q ? fill_q : buf_q;
        if (bus.gnt) begin
          if (bus.err) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            dst_d   = dst_q + 32'd4;
            words_d = words_q + LEN_WIDTH'(1);
            rem_d   = rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) begin
              state_d = StDone;
            end else if (mode_q) begin
              state_d = StWr;
            end else begin
              state_d = StRd;
            end
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy_o       = (state_q == StRd) || (state_q == StRwait) || (state_q == StWr);
  assign done_o       = (state_q == StDone);
  assign err_o        = err_q;
  assign words_done_o = words_q;

endmodule

// File: tb/tb_data_ram_dma.sv
// Directed bench for data_ram_dma with a behavioural data-RAM model that
// supports grant stalls and error injection on a chosen write.
module tb_data_ram_dma;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] len;
  logic [31:0] fill;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words;

  bus_if bus_m ();

  data_ram_dma #(.LEN_WIDTH(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .mode_i       (mode),
    .src_addr_i   (src),
    .dst_addr_i   (dst),
    .len_i        (len),
    .fill_data_i  (fill),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .words_done_o (words),
    .bus          (bus_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model
  logic [31:0] mem [logic [31:0]];
  logic        rvalid_q = 1'b0;
  logic [31:0] rdata_q  = 32'h0;
  int          cyc       = 0;
  int          wr_grants = 0;
  int          stall_end = 0;
  int          err_at    = -1;

  assign bus_m.gnt    = bus_m.req && (cyc >= stall_end);
  assign bus_m.err    = bus_m.req && bus_m.gnt && bus_m.we && (wr_grants == err_at);
  assign bus_m.rvalid = rvalid_q;
  assign bus_m.rdata  = rdata_q;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rvalid_q <= 1'b0;
    if (bus_m.req && bus_m.gnt) begin
      if (bus_m.we) begin
        wr_grants <= wr_grants + 1;
        if (!bus_m.err) mem[bus_m.addr] = bus_m.wdata;
      end else begin
        rvalid_q <= 1'b1;
        rdata_q  <= mem.exists(bus_m.addr) ? mem[bus_m.addr] : 32'h0;
      end
    end
  end

  // Activity and stall-stability monitor
  int          req_cnt   = 0;
  int          busy_cnt  = 0;
  int          stall_bad = 0;
  logic        prev_stall = 1'b0;
  logic [68:0] snap = '0;

  always @(negedge clk) begin
    if (bus_m.req) req_cnt++;
    if (busy) busy_cnt++;
    if (prev_stall && (!bus_m.req ||
        snap != {bus_m.we, bus_m.be, bus_m.addr, bus_m.wdata})) stall_bad++;
    prev_stall = bus_m.req && !bus_m.gnt;
    snap       = {bus_m.we, bus_m.be, bus_m.addr, bus_m.wdata};
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hxxxx_xxxx;
  endfunction

  // Starts a transfer in cycle 0 and returns the cycle done_o was seen in
  // (-1 if never within the budget). Ends with the DUT back in IDLE.
  task automatic run_xfer(input logic m, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] n, input logic [31:0] f, input int stalls,
                          output int dc);
    @(posedge clk); #1;
    start = 1'b1; mode = m; src = s; dst = d; len = n; fill = f;
    stall_end = cyc + 1 + stalls;
    req_cnt = 0; busy_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    dc = -1;
    for (int c = 1; c < 300; c++) begin
      if (done) begin
        dc = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("done_one_cycle", {31'h0, done}, 32'h0);
  endtask

  int dc;

  initial begin
    rst_n = 1'b0;
    start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill = '0;
    #12;
    check("rst_status", {busy, done, err, words}, 32'h0);
    check("rst_bus_ctl", {bus_m.req, bus_m.we, bus_m.be}, 32'h0);
    check("rst_bus_addr", bus_m.addr, 32'h0);
    check("rst_bus_wdata", bus_m.wdata, 32'h0);
    rst_n = 1'b1;

    // Copy 4 words
    for (int i = 0; i < 4; i++) mem[32'h100 + 4 * i] = i + 1;
    run_xfer(1'b0, 32'h100, 32'h4200, 16'd4, 32'h0, 0, dc);
    check("copy_done_cyc", dc, 32'd13);
    for (int i = 0; i < 4; i++) check("copy_data", rd_mem(32'h4200 + 4 * i), i + 1);
    check("copy_words", {16'h0, words}, 32'd4);
    check("copy_err", {31'h0, err}, 32'h0);
    check("copy_req_cycles", req_cnt, 32'd8);
    check("idle_bus", {bus_m.req, bus_m.we, bus_m.be} | bus_m.addr | bus_m.wdata, 32'h0);

    // Fill 3 words
    run_xfer(1'b1, 32'h0, 32'h8000, 16'd3, 32'hDEADBEEF, 0, dc);
    check("fill_done_cyc", dc, 32'd4);
    check("fill_w0", rd_mem(32'h8000), 32'hDEADBEEF);
    check("fill_w1", rd_mem(32'h8004), 32'hDEADBEEF);
    check("fill_w2", rd_mem(32'h8008), 32'hDEADBEEF);
    check("fill_no_w3", mem.exists(32'h800C), 32'h0);
    check("fill_busy_cycles", busy_cnt, 32'd3);

    // Zero length
    run_xfer(1'b0, 32'h100, 32'h7000, 16'd0, 32'h0, 0, dc);
    check("zero_done_cyc", dc, 32'd1);
    check("zero_req", req_cnt, 32'h0);
    check("zero_busy", busy_cnt, 32'h0);
    check("zero_words", {16'h0, words}, 32'h0);

    // Five stall cycles on the first read of a 1-word copy
    mem[32'h500] = 32'hCAFEF00D;
    stall_bad = 0;
    run_xfer(1'b0, 32'h500, 32'h600, 16'd1, 32'h0, 5, dc);
    check("stall_done_cyc", dc, 32'd9);
    check("stall_stable", stall_bad, 32'h0);
    check("stall_data", rd_mem(32'h600), 32'hCAFEF00D);

    // Error on the second granted write of a 4-word fill
    err_at = wr_grants + 1;
    run_xfer(1'b1, 32'h0, 32'h9000, 16'd4, 32'h11112222, 0, dc);
    err_at = -1;
    check("err_done_cyc", dc, 32'd3);
    check("err_flag", {31'h0, err}, 32'h1);
    check("err_words", {16'h0, words}, 32'd1);
    check("err_req_cycles", req_cnt, 32'd2);
    check("err_no_w1", mem.exists(32'h9004), 32'h0);
    run_xfer(1'b0, 32'h0, 32'h0, 16'd0, 32'h0, 0, dc);
    check("err_cleared", {31'h0, err}, 32'h0);

    // Address wrap; low address bits ignored
    run_xfer(1'b1, 32'h0, 32'hFFFF_FFFE, 16'd2, 32'h5A5A1234, 0, dc);
    check("wrap_done_cyc", dc, 32'd3);
    check("wrap_top", rd_mem(32'hFFFF_FFFC), 32'h5A5A1234);
    check("wrap_zero", rd_mem(32'h0), 32'h5A5A1234);

    // Reset during RWAIT of a copy
    mem[32'h200] = 32'hA5A50001;
    mem[32'h204] = 32'hA5A50002;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; src = 32'h200; dst = 32'h300; len = 16'd2;
    stall_end = 0;
    @(posedge clk); #1;
    start = 1'b0;
    check("mrst_rd_req", {31'h0, bus_m.req}, 32'h1);
    @(posedge clk); #1;
    check("mrst_rwait_busy", {bus_m.req, busy}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_status", {busy, done, err, words}, 32'h0);
    check("mrst_bus", {bus_m.req, bus_m.we, bus_m.be} | bus_m.addr | bus_m.wdata, 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_rvalid_ignored", {busy, bus_m.req}, 32'h0);
    @(posedge clk); #1;
    check("mrst_no_write", mem.exists(32'h300), 32'h0);
    run_xfer(1'b0, 32'h200, 32'h300, 16'd2, 32'h0, 0, dc);
    check("post_rst_done_cyc", dc, 32'd7);
    check("post_rst_w0", rd_mem(32'h300), 32'hA5A50001);
    check("post_rst_w1", rd_mem(32'h304), 32'hA5A50002);
    check("post_rst_words", {16'h0, words}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
